ppu_bg_fetch: RTL



---
 rtl/ppu_bg_fetch.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ppu_bg_fetch.sv
// Background tile fetcher: walks one scanline of tiles over a req/ack VRAM port
// and serialises 256 background pixels through a staging buffer and an 8-pixel slot.
module ppu_bg_fetch #(
  parameter logic [13:0] PAT_BASE = 14'h0000,
  parameter logic [13:0] NT_BASE  = 14'h2000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic [11:0] pos,
  input  logic [4:0]  tile_row,
  input  logic [2:0]  fine_y,
  output logic        mem_req,
  output logic [13:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [3:0]  pixel,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {StIdle, StNt, StAt, StLo, StHi, StHold} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [13:0] addr_q, addr_d;
  logic [4:0]  col_q, col_d, row_q, row_d;
  logic        nt_q, nt_d;
  logic [2:0]  fy_q, fy_d, skip_q, skip_d, disc_q, disc_d;
  logic [7:0]  tile_q, tile_d, lo_q, lo_d;
  logic [1:0]  pal_q, pal_d;
  logic [5:0]  tcnt_q, tcnt_d;
  logic        stg_full_q, stg_full_d;
  logic [7:0]  stg_lo_q, stg_lo_d, stg_hi_q, stg_hi_d;
  logic [1:0]  stg_pal_q, stg_pal_d;
  logic [7:0]  sl_lo_q, sl_lo_d, sl_hi_q, sl_hi_d;
  logic [1:0]  sl_pal_q, sl_pal_d;
  logic [3:0]  sl_cnt_q, sl_cnt_d;
  logic [8:0]  pcnt_q, pcnt_d;
  logic        busy_q, busy_d, done_q, done_d, pv_q, pv_d;
  logic [3:0]  pix_q, pix_d;

  logic        go, ack, consume, drop;
  logic [2:0]  at_sh;
  logic [5:0]  limit;
  logic        unused_pos;

  assign go         = start & ~busy_q;
  assign ack        = req_q & mem_ack;
  assign consume    = pv_q & pix_ready;
  assign drop       = (disc_q != 3'd0) && (sl_cnt_q != 4'd0);
  assign at_sh      = {row_q[1], col_q[1], 1'b0};
  assign limit      = (skip_q == 3'd0) ? 6'd32 : 6'd33;
  assign unused_pos = ^pos[11:9];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    nt_d       = nt_q;
    fy_d       = fy_q;
    skip_d     = skip_q;
    disc_d     = disc_q;
    tile_d     = tile_q;
    lo_d       = lo_q;
    pal_d      = pal_q;
    tcnt_d     = tcnt_q;
    stg_full_d = stg_full_q;
    stg_lo_d   = stg_lo_q;
    stg_hi_d   = stg_hi_q;
    stg_pal_d  = stg_pal_q;
    sl_lo_d    = sl_lo_q;
    sl_hi_d    = sl_hi_q;
    sl_pal_d   = sl_pal_q;
    sl_cnt_d   = sl_cnt_q;
    pcnt_d     = pcnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          col_d      = pos[7:3];
          nt_d       = pos[8];
          skip_d     = pos[2:0];
          disc_d     = pos[2:0];
          row_d      = tile_row;
          fy_d       = fine_y;
          tcnt_d     = 6'd0;
          pcnt_d     = 9'd0;
          stg_full_d = 1'b0;
          sl_cnt_d   = 4'd0;
          busy_d     = 1'b1;
          state_d    = StNt;
        end
      end
      StNt: if (ack) begin
        tile_d  = mem_rdata;
        state_d = StAt;
      end
      StAt: if (ack) begin
        pal_d   = mem_rdata[at_sh +: 2];
        state_d = StLo;
      end
      StLo: if (ack) begin
        lo_d    = mem_rdata;
        state_d = StHi;
      end
      StHi: if (ack) begin
        stg_lo_d   = lo_q;
        stg_hi_d   = mem_rdata;
        stg_pal_d  = pal_q;
        stg_full_d = 1'b1;
        col_d      = col_q + 5'd1;
        nt_d       = (col_q == 5'd31) ? ~nt_q : nt_q;
        tcnt_d     = tcnt_q + 6'd1;
        state_d    = StHold;
      end
      StHold: begin
        if (tcnt_q == limit) begin
          state_d = StIdle;
        end else if (!stg_full_q) begin
          state_d = StNt;
        end
      end
      default: state_d = StIdle;
    endcase

    // A request is raised one cycle after entering a fetch state and dropped on its ack.
    req_d = (state_q inside {StNt, StAt, StLo, StHi}) && (state_d == state_q);

    if (state_d != state_q) begin
      case (state_d)
        StNt:    addr_d = NT_BASE + {3'b000, nt_d, row_d, col_d};
        StAt:    addr_d = NT_BASE + {3'b000, nt_d, 4'b1111, row_d[4:2], col_d[4:2]};
        StLo:    addr_d = PAT_BASE + {2'b00, tile_d, 1'b0, fy_d};
        StHi:    addr_d = PAT_BASE + {2'b00, tile_d, 1'b1, fy_d};
        default: ;
      endcase
    end

    // Fine-x discards and accepted pixels both shift the slot, MSB first.
    if (consume || drop) begin
      sl_lo_d  = {sl_lo_q[6:0], 1'b0};
      sl_hi_d  = {sl_hi_q[6:0], 1'b0};
      sl_cnt_d = sl_cnt_q - 4'd1;
    end
    if (drop) begin
      disc_d = disc_q - 3'd1;
    end
    if (consume) begin
      pcnt_d = pcnt_q + 9'd1;
    end
    if (sl_cnt_d == 4'd0 && stg_full_q) begin
      sl_lo_d    = stg_lo_q;
      sl_hi_d    = stg_hi_q;
      sl_pal_d   = stg_pal_q;
      sl_cnt_d   = 4'd8;
      stg_full_d = 1'b0;
    end
    if (consume && pcnt_q == 9'd255) begin
      done_d     = 1'b1;
      busy_d     = 1'b0;
      sl_cnt_d   = 4'd0;
      stg_full_d = 1'b0;
    end

    pv_d  = busy_d && (sl_cnt_d != 4'd0) && (disc_d == 3'd0);
    pix_d = pv_d ? {sl_pal_d, sl_hi_d[7], sl_lo_d[7]} : 4'd0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      addr_q     <= 14'd0;
      col_q      <= 5'd0;
      row_q      <= 5'd0;
      nt_q       <= 1'b0;
      fy_q       <= 3'd0;
      skip_q     <= 3'd0;
      disc_q     <= 3'd0;
      tile_q     <= 8'd0;
      lo_q       <= 8'd0;
      pal_q      <= 2'd0;
      tcnt_q     <= 6'd0;
      stg_full_q <= 1'b0;
      stg_lo_q   <= 8'd0;
      stg_hi_q   <= 8'd0;
      stg_pal_q  <= 2'd0;
      sl_lo_q    <= 8'd0;
      sl_hi_q    <= 8'd0;
      sl_pal_q   <= 2'd0;
      sl_cnt_q   <= 4'd0;
      pcnt_q     <= 9'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pv_q       <= 1'b0;
      pix_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      nt_q       <= nt_d;
      fy_q       <= fy_d;
      skip_q     <= skip_d;
      disc_q     <= disc_d;
      tile_q     <= tile_d;
      lo_q       <= lo_d;
      pal_q      <= pal_d;
      tcnt_q     <= tcnt_d;
      stg_full_q <= stg_full_d;
      stg_lo_q   <= stg_lo_d;
      stg_hi_q   <= stg_hi_d;
      stg_pal_q  <= stg_pal_d;
      sl_lo_q    <= sl_lo_d;
      sl_hi_q    <= sl_hi_d;
      sl_pal_q   <= sl_pal_d;
      sl_cnt_q   <= sl_cnt_d;
      pcnt_q     <= pcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pv_q       <= pv_d;
      pix_q      <= pix_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign pix_valid = pv_q;
  assign pixel     = pix_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
